fas_serial: RTL and testbench

Parametrised serial adder/subtractor and the sequential successor of the single-bit full adder/subtractor cell. It takes two WIDTH-bit operands and an add/not-subtract control. It processes DIGIT bits per clock through a chain of DIGIT full adder/subtractor stages, with a carry register between cycles. It returns the WIDTH-bit result, the carry out and the signed overflow flag, using a start/busy/done handshake.

---
 rtl/fas_serial.sv | 185 ++++++++++++++++++
 tb/tb_fas_serial.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fas_serial.sv
// fas_serial: digit-serial adder/subtractor with a start/busy/done handshake.
// Each clock passes DIGIT bits of the operands through a chain of DIGIT full
// adder/subtractor stages. A carry register links one clock to the next.
// A full operation takes N = WIDTH/DIGIT RUN cycles.
//
// Ports
//   clk     in   rising-edge clock
//   rst_n   in   asynchronous active-low reset
//   start   in   request; sampled only in IDLE and DONE
//   a, b    in   WIDTH-bit operands, captured on the accepting edge
//   a_ns    in   1 = a + b, 0 = a - b, captured on the accepting edge
//   busy    out  high while the operation is running
//   done    out  one-cycle pulse when result/cout/ovf are valid
//   result  out  WIDTH-bit sum or difference, held until the next completion
//   cout    out  final carry; for subtraction 1 means a >= b (unsigned)
//   ovf     out  two's-complement overflow
module fas_serial #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             a_ns,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned N  = WIDTH / DIGIT;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  // Reject parameter combinations that cannot form whole digits.
  generate
    if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_param_err
      $error("fas_serial: WIDTH must be >= 2 and a multiple of DIGIT >= 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic accept_c;
  logic step_c;
  logic last_c;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] r_sr;
  logic             add_q;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic [DIGIT-1:0] sum_c;
  logic             c_msb_in_c;
  logic             c_out_c;
  logic [WIDTH-1:0] r_next_c;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and datapath control.
  always_comb begin
    state_nxt = state;
    accept_c  = 1'b0;
    step_c    = 1'b0;
    last_c    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          accept_c  = 1'b1;
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        step_c = 1'b1;
        if (cnt == CW'(N - 1)) begin
          last_c    = 1'b1;
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        // start here chains straight into the next operation.
        if (start) begin
          accept_c  = 1'b1;
          state_nxt = S_RUN;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Ripple chain of DIGIT full adder/subtractor stages for the current digit.
  // The carry into the top stage is kept aside for the overflow flag.
  always_comb begin
    logic c;
    logic bp;
    sum_c      = '0;
    c_msb_in_c = 1'b0;
    c          = carry;
    bp         = 1'b0;
    for (int i = 0; i < int'(DIGIT); i++) begin
      bp       = add_q ? b_sr[i] : ~b_sr[i];
      sum_c[i] = a_sr[i] ^ bp ^ c;
      if (i == int'(DIGIT) - 1) begin
        c_msb_in_c = c;
      end
      c = (a_sr[i] & bp) | (a_sr[i] & c) | (bp & c);
    end
    c_out_c = c;
  end

  // New sum digit enters the result shift register from the top.
  assign r_next_c = (r_sr >> DIGIT) | (WIDTH'(sum_c) << (WIDTH - DIGIT));

  // Operand/result shift registers, carry and digit counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr  <= '0;
      b_sr  <= '0;
      r_sr  <= '0;
      add_q <= 1'b0;
      carry <= 1'b0;
      cnt   <= '0;
    end else if (accept_c) begin
      a_sr  <= a;
      b_sr  <= b;
      r_sr  <= '0;
      add_q <= a_ns;
      carry <= ~a_ns;
      cnt   <= '0;
    end else if (step_c) begin
      a_sr  <= a_sr >> DIGIT;
      b_sr  <= b_sr >> DIGIT;
      r_sr  <= r_next_c;
      carry <= c_out_c;
      cnt   <= cnt + CW'(1);
    end
  end

  // Visible outputs change only on the final digit edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
    end else if (last_c) begin
      result <= r_next_c;
      cout   <= c_out_c;
      ovf    <= c_msb_in_c ^ c_out_c;
    end
  end

  // Handshake flags registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (state_nxt == S_RUN);
      done <= (state_nxt == S_DONE);
    end
  end

endmodule

// File: tb/tb_fas_serial.sv
// Self-checking bench for fas_serial: four WIDTH=8 instances (DIGIT 1,2,4,8)
// sharing stimulus, plus one WIDTH=4/DIGIT=2 instance for the exhaustive sweep.
module tb_fas_serial;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       a_ns;

  logic       busy_v [4];
  logic       done_v [4];
  logic [7:0] res_v  [4];
  logic       cout_v [4];
  logic       ovf_v  [4];

  logic       start4;
  logic [3:0] a4;
  logic [3:0] b4;
  logic       ns4;
  logic       busy4;
  logic       done4;
  logic [3:0] res4;
  logic       cout4;
  logic       ovf4;

  int nchk = 0;
  int nerr = 0;

  int lat8 [4];
  int nd8  [4];

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       ns;
    logic [7:0] res;
    logic       c;
    logic       v;
  } vec_t;

  vec_t vecs [8];

  genvar g;
  generate
    for (g = 0; g < 4; g++) begin : g_dut
      fas_serial #(.WIDTH(8), .DIGIT(1 << g)) u_dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .a      (a),
        .b      (b),
        .a_ns   (a_ns),
        .busy   (busy_v[g]),
        .done   (done_v[g]),
        .result (res_v[g]),
        .cout   (cout_v[g]),
        .ovf    (ovf_v[g])
      );
    end
  endgenerate

  fas_serial #(.WIDTH(4), .DIGIT(2)) u_dut4 (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start4),
    .a      (a4),
    .b      (b4),
    .a_ns   (ns4),
    .busy   (busy4),
    .done   (done4),
    .result (res4),
    .cout   (cout4),
    .ovf    (ovf4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Packs latency, done-pulse count and flags/result into one comparable word.
  function automatic logic [31:0] pk(input int lat, input int nd, input logic c,
                                     input logic v, input logic [7:0] r);
    return {8'(lat), 8'(nd), 6'd0, c, v, r};
  endfunction

  // Integer reference model: returns {ovf, cout, result}.
  function automatic logic [9:0] model(input int w, input logic [7:0] x,
                                       input logic [7:0] y, input logic ns);
    int mask, xi, yi, full, r, c, sx, sy, sr;
    logic v;
    mask = (1 << w) - 1;
    xi   = int'(x) & mask;
    yi   = int'(y) & mask;
    full = ns ? (xi + yi) : (xi + ((~yi) & mask) + 1);
    r    = full & mask;
    c    = (full >> w) & 1;
    sx   = (xi >> (w - 1)) & 1;
    sy   = (yi >> (w - 1)) & 1;
    sr   = (r >> (w - 1)) & 1;
    v    = ns ? (sx == sy && sr != sx) : (sx != sy && sr != sx);
    return {v, 1'(c), 8'(r)};
  endfunction

  // One operation on the shared 8-bit instances; records latency and done count.
  task automatic run_op8(input logic [7:0] va, input logic [7:0] vb, input logic vns);
    a     = va;
    b     = vb;
    a_ns  = vns;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      lat8[i] = 0;
      nd8[i]  = 0;
    end
    for (int k = 1; k <= 10; k++) begin
      tick();
      for (int i = 0; i < 4; i++) begin
        if (done_v[i]) begin
          nd8[i]++;
          if (lat8[i] == 0) lat8[i] = k;
        end
      end
    end
  endtask

  task automatic check_all8(input string name, input logic [7:0] er,
                            input logic ec, input logic ev);
    for (int i = 0; i < 4; i++) begin
      chk(name, pk(lat8[i], nd8[i], cout_v[i], ovf_v[i], res_v[i]),
          pk(8 >> i, 1, ec, ev, er));
    end
  endtask

  initial begin
    logic [9:0] m;
    int         lat;
    int         nd;
    int         blo;

    vecs[0] = '{a: 8'h5A, b: 8'h3C, ns: 1'b1, res: 8'h96, c: 1'b0, v: 1'b1};
    vecs[1] = '{a: 8'hFF, b: 8'h01, ns: 1'b1, res: 8'h00, c: 1'b1, v: 1'b0};
    vecs[2] = '{a: 8'h10, b: 8'h20, ns: 1'b0, res: 8'hF0, c: 1'b0, v: 1'b0};
    vecs[3] = '{a: 8'h80, b: 8'h01, ns: 1'b0, res: 8'h7F, c: 1'b1, v: 1'b1};
    vecs[4] = '{a: 8'h7F, b: 8'h01, ns: 1'b1, res: 8'h80, c: 1'b0, v: 1'b1};
    vecs[5] = '{a: 8'h00, b: 8'h01, ns: 1'b0, res: 8'hFF, c: 1'b0, v: 1'b0};
    vecs[6] = '{a: 8'h55, b: 8'h55, ns: 1'b0, res: 8'h00, c: 1'b1, v: 1'b0};
    vecs[7] = '{a: 8'h80, b: 8'h80, ns: 1'b1, res: 8'h00, c: 1'b1, v: 1'b1};

    rst_n  = 1'b1;
    start  = 1'b0;
    a      = '0;
    b      = '0;
    a_ns   = 1'b0;
    start4 = 1'b0;
    a4     = '0;
    b4     = '0;
    ns4    = 1'b0;

    // Asynchronous reset mid-cycle clears everything at once.
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("reset_async", {20'd0, busy_v[i], done_v[i], cout_v[i], ovf_v[i], res_v[i]}, 32'd0);
    end
    chk("reset_async4", {24'd0, busy4, done4, cout4, ovf4, res4}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;

    for (int k = 0; k < 10; k++) begin
      tick();
      chk("idle", {22'd0, busy_v[0], done_v[0], res_v[0]}, 32'd0);
    end

    // Directed vectors across all DIGIT values.
    for (int t = 0; t < 8; t++) begin
      run_op8(vecs[t].a, vecs[t].b, vecs[t].ns);
      check_all8("vec", vecs[t].res, vecs[t].c, vecs[t].v);
    end

    // start pulsed mid-RUN must not disturb the running operation.
    a = 8'h5A; b = 8'h3C; a_ns = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    lat = 0;
    nd  = 0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (done_v[0]) begin
        nd++;
        if (lat == 0) lat = k;
      end
      if (k == 3) begin
        a = 8'h11; b = 8'h22; a_ns = 1'b0; start = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    chk("start_in_run", pk(lat, nd, cout_v[0], ovf_v[0], res_v[0]),
        pk(8, 1, 1'b0, 1'b1, 8'h96));
    for (int k = 0; k < 12; k++) tick();

    // start held through DONE chains the next operation with no idle cycle.
    a = 8'hFF; b = 8'h01; a_ns = 1'b1; start = 1'b1;
    tick();
    a = 8'h10; b = 8'h20; a_ns = 1'b0;
    blo = 0;
    for (int k = 1; k <= 17; k++) begin
      tick();
      if (k <= 16 && !busy_v[0]) blo++;
      if (k == 8)
        chk("b2b_first", pk(int'(done_v[0]), 0, cout_v[0], ovf_v[0], res_v[0]),
            pk(1, 0, 1'b1, 1'b0, 8'h00));
      if (k == 9)
        chk("b2b_nogap", {30'd0, done_v[0], busy_v[0]}, 32'd1);
      if (k == 16) start = 1'b0;
      if (k == 17)
        chk("b2b_second", pk(int'(done_v[0]), 0, cout_v[0], ovf_v[0], res_v[0]),
            pk(1, 0, 1'b0, 1'b0, 8'hF0));
    end
    chk("b2b_busy_low", 32'(blo), 32'd1);
    for (int k = 0; k < 12; k++) tick();

    // Reset in RUN cycle 4 aborts without a done pulse.
    a = 8'h5A; b = 8'h3C; a_ns = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 4; k++) tick();
    chk("abort_pre_busy", {31'd0, busy_v[0]}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_outputs", {20'd0, busy_v[0], done_v[0], cout_v[0], ovf_v[0], res_v[0]}, 32'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    nd = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (done_v[0]) nd++;
    end
    chk("abort_no_done", 32'(nd), 32'd0);

    // Random vectors: every DIGIT must agree with the reference model.
    for (int t = 0; t < 1000; t++) begin
      logic [7:0] ra;
      logic [7:0] rb;
      logic       rn;
      ra = 8'($urandom);
      rb = 8'($urandom);
      rn = 1'($urandom);
      m  = model(8, ra, rb, rn);
      run_op8(ra, rb, rn);
      check_all8("rand8", m[7:0], m[8], m[9]);
    end

    // Exhaustive WIDTH=4/DIGIT=2 sweep with random idle gaps.
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        for (int in = 0; in < 2; in++) begin
          int gap;
          gap = int'($urandom_range(0, 3));
          for (int k = 0; k < gap; k++) tick();
          a4     = 4'(ia);
          b4     = 4'(ib);
          ns4    = 1'(in);
          start4 = 1'b1;
          tick();
          start4 = 1'b0;
          lat = 0;
          nd  = 0;
          for (int k = 1; k <= 4; k++) begin
            tick();
            if (done4) begin
              nd++;
              if (lat == 0) lat = k;
            end
          end
          m = model(4, 8'(ia), 8'(ib), 1'(in));
          chk("sweep4", pk(lat, nd, cout4, ovf4, 8'(res4)), pk(2, 1, m[8], m[9], m[7:0]));
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
